// File: rtl/usb_rw_sequencer.sv
// Task-level sequencer: turns a read/write task into a setup OUT transaction followed by a
// data IN/OUT transaction, retrying failed transactions and reporting one result pulse per task.
module usb_rw_sequencer #(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] OUT_ENDP  = 4'd4,
    parameter logic [3:0] DATA_ENDP = 4'd8,
    parameter int         DATA_W    = 64,
    parameter int         MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              task_avail,
    input  logic [1:0]        id,
    input  logic [15:0]       mempage,
    input  logic [DATA_W-1:0] data_in,
    input  logic              trans_taken,
    input  logic              success_in,
    input  logic [DATA_W-1:0] data_read,
    output logic              trans_avail,
    output logic [3:0]        pid,
    output logic [3:0]        endp,
    output logic [6:0]        addr,
    output logic [DATA_W-1:0] data_field,
    output logic              task_taken,
    output logic              success_out,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        retries
);

    typedef enum logic [1:0] {IDLE, OUT, DATA, DONE} state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

    state_t            state, state_nxt;
    logic [1:0]        id_r, id_nxt;
    logic [15:0]       page_r, page_nxt;
    logic [DATA_W-1:0] wdata_r, wdata_nxt;
    logic [DATA_W-1:0] rdata_r, rdata_nxt;
    logic [3:0]        attempt_r, attempt_nxt;
    logic [3:0]        retries_r, retries_nxt;
    logic              success_r, success_nxt;
    logic              is_read;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign is_read = (id_r == 2'b01);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id_r      <= '0;
            page_r    <= '0;
            wdata_r   <= '0;
            rdata_r   <= '0;
            attempt_r <= '0;
            retries_r <= '0;
            success_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            id_r      <= id_nxt;
            page_r    <= page_nxt;
            wdata_r   <= wdata_nxt;
            rdata_r   <= rdata_nxt;
            attempt_r <= attempt_nxt;
            retries_r <= retries_nxt;
            success_r <= success_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        id_nxt      = id_r;
        page_nxt    = page_r;
        wdata_nxt   = wdata_r;
        rdata_nxt   = rdata_r;
        attempt_nxt = attempt_r;
        retries_nxt = retries_r;
        success_nxt = success_r;
        case (state)
            IDLE: begin
                if (task_avail) begin
                    id_nxt      = id;
                    page_nxt    = mempage;
                    wdata_nxt   = data_in;
                    rdata_nxt   = '0;
                    attempt_nxt = '0;
                    retries_nxt = '0;
                    success_nxt = 1'b0;
                    state_nxt   = (id == 2'b01 || id == 2'b10) ? OUT : DONE;
                end
            end
            OUT, DATA: begin
                if (trans_taken) begin
                    if (success_in) begin
                        attempt_nxt = '0;
                        if (state == OUT) begin
                            state_nxt = DATA;
                        end else begin
                            state_nxt   = DONE;
                            success_nxt = 1'b1;
                            if (is_read) rdata_nxt = data_read;
                        end
                    end else begin
                        retries_nxt = sat_inc(retries_r);
                        // Staying in state re-issues the identical request on the next cycle.
                        if (attempt_r < RETRY_LIM) begin
                            attempt_nxt = attempt_r + 4'd1;
                        end else begin
                            state_nxt   = DONE;
                            success_nxt = 1'b0;
                        end
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        trans_avail = 1'b0;
        pid         = '0;
        endp        = '0;
        addr        = '0;
        data_field  = '0;
        task_taken  = 1'b0;
        success_out = 1'b0;
        data_out    = '0;
        retries     = '0;
        case (state)
            OUT: begin
                trans_avail = 1'b1;
                pid         = PID_OUT;
                endp        = OUT_ENDP;
                addr        = DEV_ADDR;
                data_field  = DATA_W'(page_r);
            end
            DATA: begin
                trans_avail = 1'b1;
                pid         = is_read ? PID_IN : PID_OUT;
                endp        = DATA_ENDP;
                addr        = DEV_ADDR;
                data_field  = is_read ? '0 : wdata_r;
            end
            DONE: begin
                task_taken  = 1'b1;
                success_out = success_r;
                data_out    = (success_r && is_read) ? rdata_r : '0;
                retries     = retries_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_rw_sequencer.sv
// Bench for usb_rw_sequencer: directed task table, hand-written reset/back-to-back sequences,
// and randomized tasks checked against a task-level outcome model.
module tb_usb_rw_sequencer;

    localparam int DATA_W    = 64;
    localparam int MAX_RETRY = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              task_avail;
    logic [1:0]        id;
    logic [15:0]       mempage;
    logic [DATA_W-1:0] data_in;
    logic              trans_taken;
    logic              success_in;
    logic [DATA_W-1:0] data_read;
    logic              trans_avail;
    logic [3:0]        pid;
    logic [3:0]        endp;
    logic [6:0]        addr;
    logic [DATA_W-1:0] data_field;
    logic              task_taken;
    logic              success_out;
    logic [DATA_W-1:0] data_out;
    logic [3:0]        retries;

    int vectors = 0;
    int miscompares = 0;

    usb_rw_sequencer #(
        .DEV_ADDR(7'd5), .OUT_ENDP(4'd4), .DATA_ENDP(4'd8),
        .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .task_avail(task_avail), .id(id), .mempage(mempage),
        .data_in(data_in), .trans_taken(trans_taken), .success_in(success_in),
        .data_read(data_read), .trans_avail(trans_avail), .pid(pid), .endp(endp),
        .addr(addr), .data_field(data_field), .task_taken(task_taken),
        .success_out(success_out), .data_out(data_out), .retries(retries)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] mp;
        logic [63:0] din;
        int          fo;
        int          fd;
        logic [63:0] rd;
        bit          s;
        int          r;
        logic [63:0] dout;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".trans_avail"}, 64'(trans_avail), 64'd0);
        check({tag, ".task_taken"},  64'(task_taken),  64'd0);
        check({tag, ".pid"},         64'(pid),         64'd0);
        check({tag, ".endp"},        64'(endp),        64'd0);
        check({tag, ".addr"},        64'(addr),        64'd0);
        check({tag, ".data_field"},  data_field,       64'd0);
        check({tag, ".success_out"}, 64'(success_out), 64'd0);
        check({tag, ".data_out"},    data_out,         64'd0);
        check({tag, ".retries"},     64'(retries),     64'd0);
    endtask

    // Task outcome from the counts of failures planned for each transaction.
    task automatic model(input logic [1:0] tid, input int fo, input int fd, input logic [63:0] rd,
                         output bit s, output int r, output logic [63:0] dout);
        s = 1'b0; r = 0; dout = '0;
        if (tid == 2'b01 || tid == 2'b10) begin
            if (fo > MAX_RETRY) r = MAX_RETRY + 1;
            else if (fd > MAX_RETRY) r = fo + MAX_RETRY + 1;
            else begin
                s = 1'b1;
                r = fo + fd;
                dout = (tid == 2'b01) ? rd : '0;
            end
        end
        if (r > 15) r = 15;
    endtask

    task automatic run_task(input logic [1:0] tid, input logic [15:0] mp, input logic [63:0] din,
                            input int fo, input int fd, input logic [63:0] rd,
                            input bit es, input int er, input logic [63:0] ed, input int stall);
        int  phase;
        int  cnt;
        int  plan;
        bit  done;
        @(negedge clk);
        task_avail = 1'b1; id = tid; mempage = mp; data_in = din; trans_taken = 1'b0;
        phase = (tid == 2'b01 || tid == 2'b10) ? 0 : 2;
        cnt = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            task_avail = 1'b0;
            id = 2'($urandom);
            mempage = 16'($urandom);
            data_in = {$urandom, $urandom};
            trans_taken = 1'b0;
            success_in = 1'($urandom);
            data_read = {$urandom, $urandom};
            if (phase == 2) begin
                check("done.task_taken",  64'(task_taken),  64'd1);
                check("done.trans_avail", 64'(trans_avail), 64'd0);
                check("done.pid",         64'(pid),         64'd0);
                check("done.data_field",  data_field,       64'd0);
                check("done.success_out", 64'(success_out), 64'(es));
                check("done.retries",     64'(retries),     64'(er));
                check("done.data_out",    data_out,         ed);
                done = 1'b1;
            end else begin
                check("xfer.trans_avail", 64'(trans_avail), 64'd1);
                check("xfer.task_taken",  64'(task_taken),  64'd0);
                check("xfer.addr",        64'(addr),        64'd5);
                if (phase == 0) begin
                    check("out.pid",        64'(pid),  64'b0001);
                    check("out.endp",       64'(endp), 64'd4);
                    check("out.data_field", data_field, 64'(mp));
                end else begin
                    check("data.pid",  64'(pid),  (tid == 2'b01) ? 64'b1001 : 64'b0001);
                    check("data.endp", 64'(endp), 64'd8);
                    check("data.data_field", data_field, (tid == 2'b01) ? 64'd0 : din);
                end
                if (int'($urandom_range(99)) >= stall) begin
                    trans_taken = 1'b1;
                    plan = (phase == 0) ? fo : fd;
                    if (cnt < plan) begin
                        success_in = 1'b0;
                        cnt++;
                        if (cnt > MAX_RETRY) phase = 2;
                    end else begin
                        success_in = 1'b1;
                        if (phase == 1) data_read = rd;
                        cnt = 0;
                        phase = (phase == 0) ? 1 : 2;
                    end
                end
            end
        end
        if (!done) begin
            miscompares++;
            $display("FAIL timeout: task id %0d got no task_taken expected within 200 cycles", tid);
        end
        @(negedge clk);
        trans_taken = 1'b0;
        check("after.task_taken",  64'(task_taken),  64'd0);
        check("after.trans_avail", 64'(trans_avail), 64'd0);
    endtask

    initial begin
        bit          ms;
        int          mr;
        logic [63:0] md;
        logic [1:0]  rid;
        int          rfo, rfd;

        vt[0] = '{2'b01, 16'd80,  64'd0,   0, 0, 64'd90,  1'b1, 0, 64'd90};
        vt[1] = '{2'b10, 16'd7,   64'd400, 0, 0, 64'd123, 1'b1, 0, 64'd0};
        vt[2] = '{2'b01, 16'd3,   64'd0,   2, 0, 64'd55,  1'b1, 2, 64'd55};
        vt[3] = '{2'b01, 16'd9,   64'd0,   4, 0, 64'd66,  1'b0, 4, 64'd0};
        vt[4] = '{2'b11, 16'd1,   64'd1,   0, 0, 64'd1,   1'b0, 0, 64'd0};
        vt[5] = '{2'b00, 16'd2,   64'd2,   0, 0, 64'd2,   1'b0, 0, 64'd0};
        vt[6] = '{2'b10, 16'hFFFF, 64'hDEAD_BEEF_0123_4567, 3, 3, 64'd9, 1'b1, 6, 64'd0};
        vt[7] = '{2'b01, 16'h1234, 64'd0, 1, 4, 64'd77, 1'b0, 5, 64'd0};

        rst = 1'b1; task_avail = 1'b0; id = 2'b00; mempage = '0; data_in = '0;
        trans_taken = 1'b0; success_in = 1'b0; data_read = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        // Completions offered while idle must be ignored.
        trans_taken = 1'b1; success_in = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("idle_taken");
        trans_taken = 1'b0;

        for (int i = 0; i < 8; i++)
            run_task(vt[i].id, vt[i].mp, vt[i].din, vt[i].fo, vt[i].fd, vt[i].rd,
                     vt[i].s, vt[i].r, vt[i].dout, 0);

        // Reset while in DATA with a completion pending.
        @(negedge clk);
        task_avail = 1'b1; id = 2'b01; mempage = 16'd11;
        @(negedge clk);
        task_avail = 1'b0; trans_taken = 1'b1; success_in = 1'b1;
        @(negedge clk);
        check("rst.in_data_pid", 64'(pid), 64'b1001);
        rst = 1'b1; trans_taken = 1'b1; success_in = 1'b1; data_read = 64'd77;
        @(negedge clk);
        rst = 1'b0; trans_taken = 1'b0;
        check_quiet("rst_mid");
        @(negedge clk);
        check_quiet("rst_after");
        run_task(2'b01, 16'd80, 64'd0, 0, 0, 64'd90, 1'b1, 0, 64'd90, 0);

        // task_avail held through DONE is taken as a fresh task on the following cycle.
        @(negedge clk);
        task_avail = 1'b1; id = 2'b11;
        @(negedge clk);
        check("b2b.first", 64'(task_taken), 64'd1);
        @(negedge clk);
        check("b2b.gap", 64'(task_taken), 64'd0);
        @(negedge clk);
        task_avail = 1'b0;
        check("b2b.second", 64'(task_taken), 64'd1);
        @(negedge clk);
        check("b2b.end", 64'(task_taken), 64'd0);

        for (int n = 0; n < 150; n++) begin
            rid = 2'($urandom);
            rfo = int'($urandom_range(5));
            rfd = int'($urandom_range(5));
            md = {$urandom, $urandom};
            model(rid, rfo, rfd, md, ms, mr, md);
            run_task(rid, 16'($urandom), {$urandom, $urandom}, rfo, rfd,
                     (rid == 2'b01 && ms) ? md : 64'd0, ms, mr, md, 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_rw_sequencer.md
USB_RW_SEQUENCER -- requirements
Module: usb_rw_sequencer

Interface
REQ-001 Parameters: DEV_ADDR, 7'd5, device address driven on addr during active transactions.
REQ-002 Parameters: OUT_ENDP, 4'd4, endpoint of the setup OUT transaction.
REQ-003 Parameters: DATA_ENDP, 4'd8, endpoint of the data IN/OUT transaction.
REQ-004 Parameters: DATA_W, 64, data path width; SHALL be >= 16.
REQ-005 Parameters: MAX_RETRY, 3, retries allowed per transaction after the first attempt; range 0..15.
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 Port: clk  in  1  clock, all state updates on rising edge.
REQ-008 Port: rst  in  1  synchronous active-high reset.
REQ-009 Port: task_avail  in  1  requester has a task pending.
REQ-010 Port: id  in  2  task kind: 2'b01 read, 2'b10 write, 2'b00/2'b11 illegal.
REQ-011 Port: mempage  in  16  memory page for the setup OUT transaction.
REQ-012 Port: data_in  in  DATA_W  write payload.
REQ-013 Port: trans_taken  in  1  protocol FSM completes the current transaction this cycle.
REQ-014 Port: success_in  in  1  completion status, valid only with trans_taken.
REQ-015 Port: data_read  in  DATA_W  IN payload, valid only with trans_taken.
REQ-016 Port: trans_avail / pid[3:0] / endp[3:0] / addr[6:0] / data_field[DATA_W]  out  transaction request and fields.
REQ-017 Port: task_taken  out  1  one-cycle task completion pulse.
REQ-018 Port: success_out  out  1 / data_out  out  DATA_W / retries  out  4  task result, valid only while task_taken=1.

Function
REQ-019 States: IDLE, OUT, DATA, DONE; all outputs SHALL decode from state and internal registers only, with no combinational input-to-output path.
REQ-020 IDLE: on task_avail=1, latch id, mempage, data_in; go to OUT if id is legal, else go to DONE with success_out=0.
REQ-021 Latency: task_avail sampled at edge k -> trans_avail=1 after edge k; illegal id -> task_taken=1 after edge k.
REQ-022 OUT: trans_avail=1, pid=4'b0001, endp=OUT_ENDP, addr=DEV_ADDR, data_field=zero-extended latched mempage.
REQ-023 DATA, read: trans_avail=1, pid=4'b1001, endp=DATA_ENDP, addr=DEV_ADDR, data_field=0.
REQ-024 DATA, write: trans_avail=1, pid=4'b0001, endp=DATA_ENDP, addr=DEV_ADDR, data_field=latched data_in.
REQ-025 OUT/DATA, trans_taken=1 and success_in=1: reset per-transaction attempt counter; OUT->DATA; DATA->DONE with success; read latches data_read.
REQ-026 OUT/DATA, trans_taken=1 and success_in=0: if attempt counter < MAX_RETRY, increment counter and retire-and-reissue the same transaction (stay in state; trans_avail stays 1); else go to DONE with success_out=0.
REQ-027 MAX_RETRY=0: the first failure goes directly to DONE with failure.
REQ-028 retries output SHALL be the total failed attempts over both transactions of the task, saturating at 15.
REQ-029 DONE: task_taken=1 for exactly one cycle; trans_avail=0; pid/endp/addr/data_field=0; then go to IDLE.
REQ-030 data_out SHALL equal the latched read data only for a successful read in DONE, else 0.
REQ-031 trans_taken SHALL be ignored in IDLE and DONE.
REQ-032 task_avail and id changes after acceptance SHALL NOT affect the task in flight.
REQ-033 The requester drops task_avail on task_taken; a task_avail still high in the cycle after DONE SHALL be accepted as a new task.

Reset
REQ-034 rst=1 at an edge SHALL force IDLE, clear all latched registers and counters, and drive all outputs to 0, including mid-task.
REQ-035 A pending trans_taken in the same cycle as rst SHALL be discarded; no task_taken pulse follows reset.

Verification
REQ-036 Read, defaults: id=01, mempage=80, then two successful trans_taken with data_read=90 -> OUT (pid 0001, endp 4, addr 5, data_field 80), then DATA (pid 1001, endp 8), then task_taken=1, success_out=1, data_out=90, retries=0.
REQ-037 Write: id=10, data_in=400, two successes -> DATA has pid 0001, endp 8, data_field 400; DONE gives success_out=1, data_out=0.
REQ-038 Retry: fail the OUT twice, then succeed both -> trans_avail stays 1 throughout; DONE gives success_out=1, retries=2.
REQ-039 Exhaustion, MAX_RETRY=3: four consecutive OUT failures -> DONE gives success_out=0, retries=4; DATA is never entered.
REQ-040 Illegal id=11 -> task_taken one cycle after acceptance, success_out=0, trans_avail never asserted.
REQ-041 Reset in DATA: rst=1 with trans_taken=1 -> next cycle IDLE, all outputs 0, no task_taken pulse; a new read then completes normally.
